// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2)[x] datapath: FSM encoding, grade width, operand mask.
package gf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int GF_DW   = 10;
  localparam int GRADE_W = $clog2(GF_DW) + 1;
  localparam int MASK_W  = 64;

  // Bits [g-1:0] set; callers slice the low DATA_WIDTH bits.
  function automatic logic [MASK_W-1:0] grade_mask(input logic [7:0] g);
    logic [MASK_W-1:0] m;
    for (int i = 0; i < MASK_W; i++) m[i] = (i < int'(g));
    return m;
  endfunction

endpackage

// File: rtl/cl_add.sv
// Carry-less (GF(2)) addition: coefficient-wise XOR.
module cl_add #(
  parameter int W = 20
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a ^ b;
endmodule

// File: rtl/gf_clmul_serial.sv
// Bit-serial carry-less multiplier, MSB-first over the runtime grade g.
// Emits the unreduced 2*DATA_WIDTH-bit product with valid/ready on both sides.
module gf_clmul_serial
  import gf_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [$clog2(DATA_WIDTH):0]   polyn_grade,
  input  logic [DATA_WIDTH-1:0]         a_in,
  input  logic [DATA_WIDTH-1:0]         b_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [2*DATA_WIDTH-1:0]       prod_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
);
  localparam int GW = $clog2(DATA_WIDTH) + 1;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam int PW = 2 * DATA_WIDTH;

  state_e                state_q, state_d;
  logic [PW-1:0]         acc_q, acc_d;
  logic [DATA_WIDTH-1:0] a_r_q, a_r_d, b_r_q, b_r_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [MASK_W-1:0]     mask_full;
  logic [DATA_WIDTH-1:0] mask;
  logic [GW-1:0]         grade_m1;
  logic                  grade_ok;
  logic [PW-1:0]         acc_shl, pp, acc_sum;
  logic                  unused_bits;

  assign mask_full   = grade_mask(8'(polyn_grade));
  assign mask        = mask_full[DATA_WIDTH-1:0];
  assign grade_m1    = polyn_grade - GW'(1);
  assign grade_ok    = (polyn_grade >= GW'(2)) && (polyn_grade <= GW'(DATA_WIDTH));
  assign unused_bits = ^{mask_full[MASK_W-1:DATA_WIDTH], grade_m1[GW-1:CW]};

  // Partial product is a_r when the current multiplier bit is set.
  assign acc_shl = acc_q << 1;
  assign pp      = b_r_q[cnt_q] ? {{DATA_WIDTH{1'b0}}, a_r_q} : '0;

  cl_add #(.W(PW)) u_add (
    .a (acc_shl),
    .b (pp),
    .y (acc_sum)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_r_d   = a_r_q;
    b_r_d   = b_r_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = IDLE;
      acc_d   = '0;
      a_r_d   = '0;
      b_r_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_r_d   = a_in & mask;
          b_r_d   = b_in & mask;
          acc_d   = '0;
          cnt_d   = grade_m1[CW-1:0];
          state_d = grade_ok ? RUN : DONE;
        end
        RUN: begin
          acc_d = acc_sum;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = DONE;
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_r_q   <= '0;
      b_r_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_r_q   <= a_r_d;
      b_r_q   <= b_r_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && enable;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign prod_out  = acc_q;

endmodule

// File: tb/tb_gf_clmul_serial.sv
// Scoreboard bench for gf_clmul_serial: expected products queued at accept, checked at out_valid.
module tb_gf_clmul_serial;
  localparam int DW = 10;
  localparam int GW = $clog2(DW) + 1;
  localparam int PW = 2 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic [GW-1:0] polyn_grade = '0;
  logic [DW-1:0] a_in = '0, b_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] prod_out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;
  logic [PW-1:0] sb_q[$];

  gf_clmul_serial #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .polyn_grade(polyn_grade),
    .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .in_ready(in_ready),
    .prod_out(prod_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: LSB-first shift-and-xor over the masked operands.
  function automatic logic [PW-1:0] ref_clmul(input int g, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    logic [PW-1:0] r;
    r = '0;
    if (g < 2 || g > DW) return r;
    for (int i = 0; i < g; i++)
      if (b[i]) for (int j = 0; j < g; j++) if (a[j]) r[i+j] = r[i+j] ^ 1'b1;
    return r;
  endfunction

  // Present one operation at a negedge, hold across the accepting edge, push expectation.
  task automatic start_op(input int g, input logic [DW-1:0] a, input logic [DW-1:0] b);
    polyn_grade = GW'(g);
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    sb_q.push_back(ref_clmul(g, a, b));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_in = $urandom();
    b_in = $urandom();
  endtask

  // Edges counted after the accepting edge until out_valid; capped at 40.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({in_ready, out_valid, busy, prod_out} !== {1'b1, 1'b0, 1'b0, {PW{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_state got rdy=%b vld=%b busy=%b prod=%h want 1 0 0 0",
               in_ready, out_valid, busy, prod_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    logic [PW-1:0] exp;
    out_ready = 1'b1;
    start_op(4, 10'h00B, 10'h006);
    wait_valid(lat);
    exp = sb_q.pop_front();
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL basic_latency got %0d want 4", lat);
    end
    vectors++;
    if (prod_out !== exp || prod_out !== 20'h0003A) begin
      miscompares++;
      $display("FAIL basic_prod got %h want %h", prod_out, exp);
    end
    handshake();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_return got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_full_grade();
    int lat;
    logic [PW-1:0] exp;
    logic [DW-1:0] av[2] = '{10'h3FF, 10'h200};
    logic [PW-1:0] kv[2] = '{20'h55555, 20'h40000};
    for (int k = 0; k < 2; k++) begin
      start_op(10, av[k], av[k]);
      wait_valid(lat);
      exp = sb_q.pop_front();
      vectors++;
      if (lat !== 10 || prod_out !== exp || prod_out !== kv[k]) begin
        miscompares++;
        $display("FAIL full_grade_%0d got lat=%0d prod=%h want lat=10 prod=%h",
                 k, lat, prod_out, kv[k]);
      end
      handshake();
    end
  endtask

  task automatic test_mask();
    int lat;
    logic [PW-1:0] exp;
    start_op(4, 10'h3FB, 10'h3F6);
    wait_valid(lat);
    exp = sb_q.pop_front();
    vectors++;
    if (prod_out !== exp || prod_out !== 20'h0003A) begin
      miscompares++;
      $display("FAIL mask_prod got %h want 0003a", prod_out);
    end
    handshake();
  endtask

  task automatic test_invalid_grade();
    int gv[2] = '{1, 15};
    int lat;
    logic [PW-1:0] exp;
    for (int k = 0; k < 2; k++) begin
      start_op(gv[k], 10'h3FF, 10'h2A5);
      wait_valid(lat);
      exp = sb_q.pop_front();
      vectors++;
      if (lat !== 0 || prod_out !== exp || prod_out !== '0) begin
        miscompares++;
        $display("FAIL invalid_g%0d got lat=%0d prod=%h want lat=0 prod=0",
                 gv[k], lat, prod_out);
      end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    logic [PW-1:0] exp;
    out_ready = 1'b0;
    start_op(4, 10'h00B, 10'h006);
    wait_valid(lat);
    exp = sb_q.pop_front();
    in_valid = 1'b1;
    a_in = 10'h3FF;
    b_in = 10'h3FF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (prod_out !== exp || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0 || exp !== 20'h0003A) begin
      miscompares++;
      $display("FAIL backpressure_hold bad_cycles=%0d prod=%h want 0 bad, prod %h", bad, prod_out, exp);
    end
    in_valid = 1'b0;
    handshake();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_release got vld=%b rdy=%b busy=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic check_recover(input string nm);
    int lat;
    logic [PW-1:0] exp;
    start_op(4, 10'h00B, 10'h006);
    wait_valid(lat);
    exp = sb_q.pop_front();
    vectors++;
    if (lat !== 4 || prod_out !== exp || prod_out !== 20'h0003A) begin
      miscompares++;
      $display("FAIL %s_recover got lat=%0d prod=%h want 4 0003a", nm, lat, prod_out);
    end
    handshake();
  endtask

  task automatic test_abort_rst();
    int pulses = 0;
    start_op(4, 10'h00B, 10'h006);
    void'(sb_q.pop_back());
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_rst_idle got busy=%b vld=%b rdy=%b want 0 0 1", busy, out_valid, in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL abort_rst_pulse got %0d out_valid cycles want 0", pulses);
    end
    check_recover("abort_rst");
  endtask

  task automatic test_abort_enable();
    int pulses = 0;
    start_op(4, 10'h00B, 10'h006);
    void'(sb_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || prod_out !== '0) begin
      miscompares++;
      $display("FAIL abort_en_idle got busy=%b vld=%b rdy=%b prod=%h want 0 0 0 0",
               busy, out_valid, in_ready, prod_out);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) pulses++;
      if (c == 2) enable = 1'b1;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL abort_en_pulse got %0d out_valid cycles want 0", pulses);
    end
    check_recover("abort_en");
  endtask

  task automatic test_back_to_back();
    int lat;
    int g;
    logic [PW-1:0] exp;
    for (int k = 0; k < 6; k++) begin
      g = $urandom_range(2, DW);
      start_op(g, DW'($urandom()), DW'($urandom()));
      wait_valid(lat);
      exp = sb_q.pop_front();
      vectors++;
      if (lat !== g || prod_out !== exp) begin
        miscompares++;
        $display("FAIL b2b_%0d g=%0d got lat=%0d prod=%h want lat=%0d prod=%h",
                 k, g, lat, prod_out, g, exp);
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_grade();
    test_mask();
    test_invalid_grade();
    test_backpressure();
    test_abort_rst();
    test_abort_enable();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gf_clmul_serial.md
Name: gf_clmul_serial

Overview:
- Bit-serial carry-less (GF(2)[x]) polynomial multiplier.
- Produces the unreduced 2*DATA_WIDTH-bit product that feeds the GF reduction stage, which consumes it as its polynomial-to-reduce input.
- Operand degree is selected at runtime by polyn_grade; one multiplier bit is processed per cycle.
- Uses a valid/ready handshake on both input and output.

Parameters:
- DATA_WIDTH, 10, maximum field degree m; operand width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- enable  input  1  synchronous clear when low: FSM to IDLE, all registers zeroed.
- polyn_grade  input  $clog2(DATA_WIDTH)+1  field degree g for this operation.
- a_in  input  DATA_WIDTH  multiplicand polynomial, LSB = x^0.
- b_in  input  DATA_WIDTH  multiplier polynomial, LSB = x^0.
- in_valid  input  1  operands and grade valid.
- in_ready  output  1  block can accept an operation.
- prod_out  output  2*DATA_WIDTH  product, LSB-aligned, bit k = coefficient of x^k.
- out_valid  output  1  prod_out valid.
- out_ready  input  1  downstream accepts prod_out.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n low, async) and enable low (sync):
  - state=IDLE; acc, a_r, b_r, cnt all 0.
  - in_ready=1 (rst_n) / 0 while enable low; out_valid=0; prod_out=0; busy=0.
- g is valid when 2 <= g <= DATA_WIDTH; any other value is invalid.
- IDLE:
  - in_ready=enable.
  - Accept on in_valid && in_ready.
  - On accept, capture a_r = a_in & mask(g) and b_r = b_in & mask(g), where mask(g) has bits [g-1:0] set. Set acc=0 and cnt=g-1.
  - Valid g: go to RUN. Invalid g: go to DONE with acc=0.
- RUN:
  - Each cycle: acc <= (acc << 1) ^ (b_r[cnt] ? {DATA_WIDTH'b0, a_r} : 0); cnt <= cnt-1. Processing is MSB-first.
  - The cycle in which cnt==0 is processed is the last one; go to DONE.
  - in_ready=0.
- DONE:
  - out_valid=1; prod_out=acc, held stable until the handshake.
  - When out_ready is high: clear out_valid and go to IDLE on the same edge.
  - New input is accepted only once back in IDLE; no overlap.
- Latency:
  - Valid g: out_valid rises exactly g cycles after the accepting edge.
  - Invalid g: out_valid rises on the accepting edge itself.
  - Throughput: at most one operation per g+2 cycles with out_ready tied high.
- Width:
  - Product degree is at most 2g-2; bits [2*DATA_WIDTH-1 : 2g-1] of prod_out are always 0.
  - The accumulator is 2*DATA_WIDTH bits; a left shift never overflows for valid g.
- Inputs are ignored outside IDLE; in_valid held high during RUN/DONE has no effect.
- out_ready is ignored unless in DONE.
- Reset or enable low mid-RUN or mid-DONE aborts the operation; the result is discarded with no out_valid pulse.

Decomposition:
- Shared package gf_pkg holds:
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a function returning mask(g);
  - the GRADE_W = $clog2(DATA_WIDTH)+1 constant.
- Accumulator XOR reuses the existing cl_add adder at width 2*DATA_WIDTH.
- No new sub-module.

Test Plan:
- DW=10, g=4, a=0x00B, b=0x006, out_ready=1 -> out_valid exactly 4 cycles after accept; prod_out=0x0003A; then in_ready=1.
- g=10, a=0x3FF, b=0x3FF -> prod_out=0x55555 after 10 cycles; g=10, a=0x200, b=0x200 -> prod_out=0x40000.
- g=4, a=0x3FB, b=0x3F6 (bits above g set) -> upper bits masked; prod_out=0x0003A.
- g=1 and g=15, any operands -> prod_out=0 with out_valid on the accepting edge.
- g=4 vector with out_ready held low 5 cycles -> prod_out stable at 0x3A, in_ready=0, busy=1; accepted on the first out_ready high.
- rst_n low at RUN cycle 2 (async) and, separately, enable low at RUN cycle 2 -> immediate IDLE, out_valid never pulses; the next operation (g=4, 0xB*0x6) returns 0x3A.
